// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// State encoding, default width and divide-by-zero quotient.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DIV_W = 8;

  localparam logic [DIV_W-1:0] DIV_ZQ = '1;

endpackage

// File: rtl/addsub_w.sv
// W-bit ripple subtractor: diff = x + ~y + 1.
// borrow is the inverted carry out of the top bit.
module addsub_w #(
  parameter int W = 9
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] c;
  logic       yn;

  // carry chain, one full adder per bit
  always_comb begin
    c    = '0;
    diff = '0;
    yn   = 1'b0;
    c[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      yn       = ~y[i];
      diff[i]  = x[i] ^ yn ^ c[i];
      c[i+1]   = (x[i] & yn) | (x[i] & c[i]) | (yn & c[i]);
    end
  end

  assign borrow = ~c[W];

endmodule

// File: rtl/divider8_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// DIV_SIGNED_EN selects two's complement operands.
module divider8_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, nstate;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;

  logic             accept;
  logic             dz;
  logic [WIDTH:0]   pp;
  logic [WIDTH:0]   d;
  logic             bw;
  logic [WIDTH:0]   pn;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

  assign ready  = (state != RUN);
  assign busy   = (state == RUN);
  assign valid  = (state == DONE);
  assign accept = start & ready;
  assign dz     = (divisor == '0);

  assign pp = {p[WIDTH-1:0], q[WIDTH-1]};

  addsub_w #(.W(WIDTH+1)) u_trial (
    .x      (pp),
    .y      ({1'b0, dvs}),
    .diff   (d),
    .borrow (bw)
  );

  assign pn = bw ? pp : d;
  assign qn = {q[WIDTH-2:0], ~bw};

`ifdef DIV_SIGNED_EN
  logic [WIDTH-1:0] na, nb, nq, nr;
  logic             bw_a, bw_b, bw_q, bw_r;
  logic             qneg, rneg, ovf_r, ovf;

  addsub_w #(.W(WIDTH)) u_nega (
    .x('0), .y(dividend), .diff(na), .borrow(bw_a)
  );
  addsub_w #(.W(WIDTH)) u_negb (
    .x('0), .y(divisor), .diff(nb), .borrow(bw_b)
  );
  addsub_w #(.W(WIDTH)) u_negq (
    .x('0), .y(qn), .diff(nq), .borrow(bw_q)
  );
  addsub_w #(.W(WIDTH)) u_negr (
    .x('0), .y(pn[WIDTH-1:0]), .diff(nr), .borrow(bw_r)
  );

  assign a_mag    = dividend[WIDTH-1] ? na : dividend;
  assign b_mag    = divisor[WIDTH-1] ? nb : divisor;
  assign res_q    = qneg ? nq : qn;
  assign res_r    = rneg ? nr : pn[WIDTH-1:0];
  assign overflow = ovf;

  // operand signs and the most-negative / -1 case, latched at accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      ovf_r <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      qneg  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg  <= dividend[WIDTH-1];
      ovf_r <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
               (&divisor);
      if (dz)
        ovf <= 1'b0;
    end else if (state == RUN && cnt == '0) begin
      ovf <= ovf_r;
    end
  end
`else
  assign a_mag    = dividend;
  assign b_mag    = divisor;
  assign res_q    = qn;
  assign res_r    = pn[WIDTH-1:0];
  assign overflow = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nstate;
  end

  // next state: DONE accepts start exactly like IDLE
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE, DONE: begin
        if (start)
          nstate = dz ? DONE : RUN;
        else
          nstate = IDLE;
      end
      RUN: begin
        if (cnt == '0)
          nstate = DONE;
      end
      default: nstate = IDLE;
    endcase
  end

  // datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      p           <= '0;
      q           <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (dz) begin
        quotient    <= {WIDTH{&DIV_ZQ}};
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        p   <= '0;
        q   <= a_mag;
        dvs <= b_mag;
        cnt <= CW'(WIDTH-1);
      end
    end else if (state == RUN) begin
      p   <= pn;
      q   <= qn;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        quotient    <= res_q;
        remainder   <= res_r;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
